dig_ctrl_spi_host: RTL and testbench
====================================

// Module: dig_ctrl_spi_host
// PURPOSE
//  SPI controller (mode 0, MSB first) that drives the dig_ctrl SPI peripheral pins
//  (sclk, mosi, cs) and samples miso. Converts a byte-wide valid/ready stream into
//  SPI transfers and returns each received byte. Used on-chip and in the bench as
//  the counterpart of dig_ctrl's SPI receiver.
// PARAMETERS
//  CLK_DIV  4  SCLK half-period in clk_i cycles (>=1); one bit = 2*CLK_DIV cycles
// PORTS
//  clk_i       in   1  system clock
//  rst_ni      in   1  reset, synchronous, active-low
//  tx_data_i   in   8  byte to transmit
//  tx_last_i   in   1  byte is last of transaction; release CS after it
//  tx_valid_i  in   1  tx_data_i/tx_last_i valid
//  tx_ready_o  out  1  host can accept a byte (accept = tx_valid_i & tx_ready_o)
//  rx_data_o   out  8  byte received on miso during the completed byte
//  rx_valid_o  out  1  one-cycle pulse, rx_data_o updated this cycle
//  busy_o      out  1  high whenever state != IDLE
//  spi_sclk_o  out  1  SPI clock, idles low (CPOL=0)
//  spi_mosi_o  out  1  SPI data out
//  spi_miso_i  in   1  SPI data in (sampled on SCLK rising edge)
//  spi_cs_o    out  1  chip select, active-low, idles high
// BEHAVIOUR
//  Reset (rst_ni low at a clk_i edge): state=IDLE, spi_cs_o=1, spi_sclk_o=0,
//   spi_mosi_o=0, rx_data_o=0, rx_valid_o=0, busy_o=0; tx_ready_o forced 0 while
//   rst_ni low. Reset mid-transfer aborts at once: CS high next cycle, no rx_valid.
//  All SPI outputs registered. div_cnt counts 0..CLK_DIV-1; its wrap = "tick".
//  States:
//   IDLE : tx_ready_o=1. On accept: load shift reg, latch last, CS low,
//          mosi=bit7, div_cnt=0 -> LEAD.
//   LEAD : CS low, SCLK low, hold; on tick -> SHIFT (first edge is rising).
//   SHIFT: SCLK toggles on each tick. Rising: sample miso into rx shift reg.
//          Falling: drive next bit on mosi. After 8th falling edge: rx_data_o <=
//          rx shift reg, rx_valid_o=1 for that cycle; last ? TRAIL : NEXT.
//   NEXT : CS low, SCLK low, tx_ready_o=1; wait indefinitely (no SCLK edges).
//          On accept: load byte, mosi=bit7 -> LEAD.
//   TRAIL: CS low, SCLK low for CLK_DIV cycles, then CS high -> GAP.
//   GAP  : CS high for CLK_DIV cycles (min CS-high time), tx_ready_o=0 -> IDLE.
//  Timing per single-byte transaction: CS low for CLK_DIV + 16*CLK_DIV + CLK_DIV
//   cycles; byte accept to CS low = 1 cycle. MOSI stable >= CLK_DIV cycles
//   before each rising edge.
//  tx_ready_o low in LEAD/SHIFT/TRAIL/GAP; tx_valid_i ignored there. tx_data_i
//   may change freely after accept. rx_valid_o has no backpressure.
//  spi_mosi_o holds last driven bit in NEXT/TRAIL; driven 0 in IDLE/GAP.
// TESTING
//  1 CLK_DIV=2, send 0xA5 last=1, slave returns 0x3C -> mosi at rising edges
//    1,0,1,0,0,1,0,1; one rx_valid pulse rx_data=0x3C; CS low exactly 36 cycles.
//  2 Burst 0x12(last=0) then 0x34(last=1) -> CS stays low between bytes, 16 SCLK
//    rising edges total, rx_valid pulses twice with respective slave bytes.
//  3 Byte 0x55 last=0, then tx_valid low 10 cycles -> CS low, SCLK low, no edges,
//    tx_ready=1 throughout NEXT; transfer resumes with LEAD on next accept.
//  4 rst_ni low for 1 cycle after 3rd rising edge -> next cycle CS=1, SCLK=0,
//    no rx_valid; subsequent 0xFF transfer completes normally.
//  5 tx_valid held high, last=1, bytes 0x01,0x02 -> CS high exactly CLK_DIV
//    cycles between transactions, tx_ready low during GAP.
//  6 CLK_DIV=1, send 0x80 last=1 -> SCLK period 2 cycles, CS low 18 cycles.

Source files
------------

// File: rtl/dig_ctrl_spi_host.sv
// ----------------------------------------------------------------------------
// dig_ctrl_spi_host
//   SPI host, mode 0 (CPOL=0, CPHA=0), MSB first. Turns a byte-wide
//   valid/ready stream into SPI transfers on sclk/mosi/cs and returns every
//   byte shifted in on miso as a one-cycle rx_valid pulse. Bytes flagged
//   tx_last_i close the transaction (CS released); other bytes keep CS low
//   and wait for the next byte.
//
// Parameters
//   CLK_DIV     SCLK half-period in clk_i cycles (>=1)
//
// Ports
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   tx_data_i   byte to transmit
//   tx_last_i   byte ends the transaction
//   tx_valid_i  tx_data_i/tx_last_i valid
//   tx_ready_o  host can take a byte (IDLE or NEXT, never during reset)
//   rx_data_o   byte received during the byte just completed
//   rx_valid_o  one-cycle pulse when rx_data_o updates
//   busy_o      high whenever the host is not IDLE
//   spi_sclk_o  SPI clock, idles low
//   spi_mosi_o  SPI data out
//   spi_miso_i  SPI data in, sampled on SCLK rising edges
//   spi_cs_o    chip select, active low, idles high
// ----------------------------------------------------------------------------
module dig_ctrl_spi_host #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] tx_data_i,
   input  logic       tx_last_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       busy_o,
   output logic       spi_sclk_o,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i,
   output logic       spi_cs_o
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_NEXT,
      S_TRAIL,
      S_GAP
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      edge_q, edge_d;     // SCLK edges already issued in this byte
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            cs_q, cs_d;
   logic [7:0]      tx_sh_q, tx_sh_d;
   logic [7:0]      rx_sh_q, rx_sh_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            last_q, last_d;

   logic            tick;
   logic            gap_done;
   logic            accept;
   logic [DW-1:0]   div_inc;

   assign tick    = (div_q == DW'(CLK_DIV - 1));
   assign div_inc = tick ? '0 : div_q + 1'b1;

   // The IDLE cycle that precedes the next accept also holds CS high, so GAP
   // only needs CLK_DIV-1 cycles to guarantee CLK_DIV cycles of CS high.
   // With CLK_DIV == 1 GAP is never entered.
   assign gap_done = (int'(div_q) == CLK_DIV - 2);

   assign tx_ready_o = rst_ni & ((state_q == S_IDLE) | (state_q == S_NEXT));
   assign accept     = tx_valid_i & tx_ready_o;

   always_comb begin
      state_d    = state_q;
      div_d      = '0;
      edge_d     = edge_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      last_d     = last_q;

      case (state_q)
         S_IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (accept) begin
               tx_sh_d = tx_data_i;
               last_d  = tx_last_i;
               cs_d    = 1'b0;
               mosi_d  = tx_data_i[7];
               edge_d  = '0;
               state_d = S_LEAD;
            end
         end

         // CS low, SCLK low: bit 7 already on mosi for a full half-period
         // before the first tick of SHIFT raises SCLK.
         S_LEAD: begin
            div_d = div_inc;
            if (tick) state_d = S_SHIFT;
         end

         S_SHIFT: begin
            div_d = div_inc;
            if (tick) begin
               edge_d = edge_q + 4'd1;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
               end else begin
                  sclk_d = 1'b0;
                  if (edge_q == 4'd15) begin
                     // 8th falling edge: byte done, mosi keeps bit 0
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     state_d    = last_q ? S_TRAIL : S_NEXT;
                  end else begin
                     mosi_d  = tx_sh_q[6];
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  end
               end
            end
         end

         S_NEXT: begin
            if (accept) begin
               tx_sh_d = tx_data_i;
               last_d  = tx_last_i;
               mosi_d  = tx_data_i[7];
               edge_d  = '0;
               state_d = S_LEAD;
            end
         end

         S_TRAIL: begin
            div_d = div_inc;
            if (tick) begin
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
               state_d = (CLK_DIV == 1) ? S_IDLE : S_GAP;
            end
         end

         S_GAP: begin
            div_d = div_inc;
            if (gap_done) begin
               div_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         edge_q     <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         edge_q     <= edge_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         last_q     <= last_d;
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign spi_sclk_o = sclk_q;
   assign spi_mosi_o = mosi_q;
   assign spi_cs_o   = cs_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_dig_ctrl_spi_host.sv
module tb_dig_ctrl_spi_host;
  localparam int CD  = 2;
  localparam int CD1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // dut: CLK_DIV=2
  logic [7:0] tx_data, rx_data;
  logic tx_last, tx_valid, tx_ready, rx_valid, busy, sclk, mosi, miso, cs;
  // dut1: CLK_DIV=1
  logic [7:0] tx_data1, rx_data1;
  logic tx_last1, tx_valid1, tx_ready1, rx_valid1, busy1, sclk1, mosi1, miso1, cs1;

  dig_ctrl_spi_host #(.CLK_DIV(CD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_last_i(tx_last),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .busy_o(busy), .spi_sclk_o(sclk), .spi_mosi_o(mosi),
    .spi_miso_i(miso), .spi_cs_o(cs));

  dig_ctrl_spi_host #(.CLK_DIV(CD1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data1), .tx_last_i(tx_last1),
    .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1), .rx_data_o(rx_data1),
    .rx_valid_o(rx_valid1), .busy_o(busy1), .spi_sclk_o(sclk1), .spi_mosi_o(mosi1),
    .spi_miso_i(miso1), .spi_cs_o(cs1));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave + monitors for dut
  logic [15:0] slv_sh, mosi_cap;
  int rise_cnt, cs_low_cnt, cs_rise_cnt;
  logic [7:0] rx_q[$];
  assign miso = slv_sh[15];
  always @(posedge sclk) begin mosi_cap = {mosi_cap[14:0], mosi}; rise_cnt++; end
  always @(negedge sclk) slv_sh = slv_sh << 1;
  always @(posedge cs) cs_rise_cnt++;
  always @(posedge clk) begin
    if (cs === 1'b0) cs_low_cnt++;
    if (rx_valid === 1'b1) rx_q.push_back(rx_data);
  end

  // slave + monitors for dut1
  logic [7:0] slv1_sh, mosi1_cap;
  int rise1_cnt, cs1_low_cnt, cyc, t_r1a, t_r1b;
  logic [7:0] rx1_q[$];
  assign miso1 = slv1_sh[7];
  always @(posedge sclk1) begin
    if (rise1_cnt == 0) t_r1a = cyc;
    if (rise1_cnt == 1) t_r1b = cyc;
    mosi1_cap = {mosi1_cap[6:0], mosi1};
    rise1_cnt++;
  end
  always @(negedge sclk1) slv1_sh = slv1_sh << 1;
  always @(posedge clk) begin
    cyc++;
    if (cs1 === 1'b0) cs1_low_cnt++;
    if (rx_valid1 === 1'b1) rx1_q.push_back(rx_data1);
  end

  task automatic clear_mon(input logic [15:0] slv);
    slv_sh = slv; mosi_cap = '0; rise_cnt = 0; cs_low_cnt = 0; cs_rise_cnt = 0;
    rx_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("send_timeout", 0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n, bad, hi;
    logic tr0;
    rst_n = 1'b0;
    tx_data = '0; tx_last = 1'b0; tx_valid = 1'b0;
    tx_data1 = '0; tx_last1 = 1'b0; tx_valid1 = 1'b0;
    cyc = 0; rise1_cnt = 0; cs1_low_cnt = 0; slv1_sh = '0; mosi1_cap = '0;
    clear_mon(16'h0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 0);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", tx_ready, 1);

    // 1: 0xA5 last, slave 0x3C
    clear_mon({8'h3C, 8'h00});
    send(8'hA5, 1'b1);
    wait_idle();
    chk("t1_mosi", mosi_cap[7:0], 8'hA5);
    chk("t1_rises", rise_cnt, 8);
    chk("t1_rx_cnt", rx_q.size(), 1);
    chk("t1_rx", rx_q[0], 8'h3C);
    chk("t1_cs_low", cs_low_cnt, 18 * CD);

    // 2: burst 0x12, 0x34
    clear_mon({8'hC3, 8'h5A});
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    wait_idle();
    chk("t2_mosi", mosi_cap, 16'h1234);
    chk("t2_rises", rise_cnt, 16);
    chk("t2_cs_rise", cs_rise_cnt, 1);
    chk("t2_rx_cnt", rx_q.size(), 2);
    chk("t2_rx0", rx_q[0], 8'hC3);
    chk("t2_rx1", rx_q[1], 8'h5A);

    // 3: 0x55 not last, stall 10 cycles in NEXT
    clear_mon({8'hAA, 8'h81});
    send(8'h55, 1'b0);
    n = 0;
    while (rx_q.size() == 0 && n < 500) begin @(negedge clk); n++; end
    chk("t3_first_rx", rx_q.size(), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cs !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    chk("t3_next_hold", bad, 0);
    chk("t3_no_edges", rise_cnt, 8);
    send(8'h0F, 1'b1);
    wait_idle();
    chk("t3_mosi", mosi_cap, 16'h550F);
    chk("t3_rx1", rx_q[1], 8'h81);
    chk("t3_cs_rise", cs_rise_cnt, 1);

    // 4: reset after 3rd rising edge
    clear_mon({8'h5A, 8'h00});
    send(8'h96, 1'b1);
    n = 0;
    while (rise_cnt < 3 && n < 500) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_ready_in_rst", tx_ready, 0);
    chk("t4_cs", cs, 1);
    chk("t4_sclk", sclk, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_no_rxv", rx_q.size(), 0);
    chk("t4_busy", busy, 0);
    clear_mon({8'h66, 8'h00});
    send(8'hFF, 1'b1);
    wait_idle();
    chk("t4_mosi", mosi_cap[7:0], 8'hFF);
    chk("t4_rx", rx_q[0], 8'h66);
    chk("t4_cs_low", cs_low_cnt, 18 * CD);

    // 5: valid held high, 0x01 then 0x02, both last
    clear_mon({8'h11, 8'h22});
    @(negedge clk);
    tx_data = 8'h01; tx_last = 1'b1; tx_valid = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tx_data = 8'h02;
    n = 0;
    while (cs === 1'b0 && n < 2000) begin @(negedge clk); n++; end
    tr0 = tx_ready;
    hi = 0;
    while (cs === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    tx_valid = 1'b0;
    chk("t5_gap_ready", tr0, 0);
    chk("t5_cs_high", hi, CD);
    wait_idle();
    chk("t5_mosi", mosi_cap, 16'h0102);
    chk("t5_rx_cnt", rx_q.size(), 2);
    chk("t5_rx1", rx_q[1], 8'h22);

    // 6: CLK_DIV=1, 0x80 last
    rise1_cnt = 0; cs1_low_cnt = 0; slv1_sh = 8'h01; mosi1_cap = '0; rx1_q.delete();
    @(negedge clk);
    tx_data1 = 8'h80; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    n = 0;
    while (tx_ready1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    tx_valid1 = 1'b0;
    n = 0;
    while (busy1 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    chk("t6_done", busy1, 0);
    chk("t6_period", t_r1b - t_r1a, 2);
    chk("t6_rises", rise1_cnt, 8);
    chk("t6_cs_low", cs1_low_cnt, 18);
    chk("t6_mosi", mosi1_cap, 8'h80);
    chk("t6_rx", rx1_q[0], 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
